// File: rtl/dm_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_uart_pkg
//  Description : Register indices, STATUS/CTRL bit positions and the
//                transmitter FSM state type for dm_uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
package dm_uart_pkg;

  // Register indices decoded from DM_addr[1:0]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_EMPTY_BIT = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_MSB   = 16;

  // CTRL bit positions
  localparam int CTRL_TXEN_BIT   = 0;
  localparam int CTRL_OVFCLR_BIT = 1;
  localparam int CTRL_ODD_BIT    = 2;

  // Transmitter FSM states; PARITY is only reachable in the parity build
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Interface   : dm_uart_tx_if
//  Description : CPU data-memory port bundle (DM_W/DM_R/DM_addr/DM_wdata/
//                DM_rdata plus block select ena).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_uart_tx_if;
  logic        ena;
  logic        DM_W;
  logic        DM_R;
  logic [10:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;

  modport master (output ena, DM_W, DM_R, DM_addr, DM_wdata, input DM_rdata);
  modport slave  (input ena, DM_W, DM_R, DM_addr, DM_wdata, output DM_rdata);
endinterface
`default_nettype wire

// File: rtl/dm_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dm_uart_fifo
//  Description : Synchronous byte FIFO with show-ahead output. A push while
//                full is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push_i,
  input  wire logic [7:0]               din_i,
  input  wire logic                     pop_i,
  output logic      [7:0]               dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic      [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign dout_o    = mem_q[rd_ptr_q];
  assign w_pop_ok  = pop_i & ~empty_o;
  assign w_push_ok = push_i & (~full_o | w_pop_ok);

  // Storage array: written on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/dm_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dm_uart_tx
//  Description : Memory-mapped UART transmitter on the CPU data-memory port.
//                TX FIFO + baud-rate FSM emitting 8N1 frames on txd.
//                Optional macro DM_UART_TX_PARITY_EN adds a parity bit
//                (even, or odd when CTRL bit2 is set).
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_uart_tx
  import dm_uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  dm_uart_tx_if.slave bus,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          tx_en_q;
  logic          ovf_q;
  logic          odd_q;
`ifdef DM_UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic          w_wr;
  logic          w_rd;
  logic          w_push;
  logic          w_ctrl_wr;
  logic          w_bit_end;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic [7:0]    w_dout;
  logic [AW:0]   w_count;
  logic [31:0]   w_rdata;
  logic          w_unused_bits;

  assign w_wr      = bus.ena & bus.DM_W;
  assign w_rd      = bus.ena & bus.DM_R;
  assign w_push    = w_wr & (bus.DM_addr[1:0] == REG_TXDATA);
  assign w_ctrl_wr = w_wr & (bus.DM_addr[1:0] == REG_CTRL);
  assign w_bit_end = (baud_q == BAUD_LAST);
  assign w_busy    = (state_q != ST_IDLE);
  // A new frame is fetched from IDLE, or straight out of STOP for gapless streaming
  assign w_pop     = tx_en_q & ~w_empty &
                     ((state_q == ST_IDLE) | ((state_q == ST_STOP) & w_bit_end));
  assign txd       = txd_q;
  assign w_unused_bits = ^{bus.DM_addr[10:2], bus.DM_wdata[31:8]};

  dm_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .din_i   (bus.DM_wdata[7:0]),
    .pop_i   (w_pop),
    .dout_o  (w_dout),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // CTRL register and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_q <= 1'b1;
      ovf_q   <= 1'b0;
      odd_q   <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        tx_en_q <= bus.DM_wdata[CTRL_TXEN_BIT];
        if (bus.DM_wdata[CTRL_OVFCLR_BIT]) ovf_q <= 1'b0;
`ifdef DM_UART_TX_PARITY_EN
        odd_q <= bus.DM_wdata[CTRL_ODD_BIT];
`endif
      end
      // A push into a full FIFO is only lost when no pop frees a slot this cycle
      if (w_push & w_full & ~w_pop) ovf_q <= 1'b1;
    end
  end

  // Serialiser FSM; txd is registered and updated on each bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef DM_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (state_q != ST_IDLE) baud_q <= w_bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (w_pop) begin
            shift_q <= w_dout;
`ifdef DM_UART_TX_PARITY_EN
            par_q   <= (^w_dout) ^ odd_q;
`endif
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            txd_q   <= shift_q[0];
            bit_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (bit_q == 3'd7) begin
`ifdef DM_UART_TX_PARITY_EN
              txd_q   <= par_q;
              state_q <= ST_PARITY;
`else
              txd_q   <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
`ifdef DM_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            txd_q   <= 1'b1;
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              shift_q <= w_dout;
`ifdef DM_UART_TX_PARITY_EN
              par_q   <= (^w_dout) ^ odd_q;
`endif
              txd_q   <= 1'b0;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational read mux, zero unless the block is selected for a read
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (bus.DM_addr[1:0])
        REG_STATUS: begin
          w_rdata[STAT_BUSY_BIT]               = w_busy;
          w_rdata[STAT_FULL_BIT]               = w_full;
          w_rdata[STAT_EMPTY_BIT]              = w_empty;
          w_rdata[STAT_OVF_BIT]                = ovf_q;
          w_rdata[STAT_CNT_MSB:STAT_CNT_LSB]   = 9'(w_count);
        end
        REG_CTRL: begin
          w_rdata[CTRL_TXEN_BIT] = tx_en_q;
          w_rdata[CTRL_ODD_BIT]  = odd_q;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.DM_rdata = w_rdata;
endmodule
`default_nettype wire

// File: tb/tb_dm_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_uart_tx
//  Description : Self-checking bench for dm_uart_tx (CLK_DIV=4, depth 4).
//                Expected serial waveforms come from a frame model built
//                from the byte value; STATUS words from a small formatter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;
  logic txd;
  int   n_checks = 0;
  int   n_errors = 0;
  logic odd_mode = 1'b0;

  dm_uart_tx_if bus ();

  dm_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status_word(input bit busy, input bit full,
                                              input bit empty, input bit ovf, input int count);
    logic [31:0] w;
    w = 32'd0;
    w[0] = busy; w[1] = full; w[2] = empty; w[3] = ovf;
    w[16:8] = 9'(count);
    return w;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ena = 1'b1; bus.DM_W = 1'b1; bus.DM_R = 1'b0;
    bus.DM_addr = {9'($urandom), a}; bus.DM_wdata = d;
    @(posedge clk); #1;
    bus.ena = 1'b0; bus.DM_W = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.ena = 1'b1; bus.DM_R = 1'b1; bus.DM_W = 1'b0;
    bus.DM_addr = {9'($urandom), a};
    #1 d = bus.DM_rdata;
    bus.ena = 1'b0; bus.DM_R = 1'b0;
  endtask

  // Checks one frame whose start bit begins on the next rising edge
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic exp_bits [11];
    int   nb;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    nb = 10;
`ifdef DM_UART_TX_PARITY_EN
    exp_bits[9] = (^b) ^ odd_mode;
    nb = 11;
`endif
    exp_bits[nb-1] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < nb; k++) begin
      int   bad;
      logic seen;
      bad = 0; seen = exp_bits[k];
      for (int c = 0; c < CLK_DIV; c++) begin
        @(negedge clk);
        if (txd !== exp_bits[k]) begin bad++; seen = txd; end
      end
      n_checks++;
      if (bad != 0) begin
        n_errors++;
        $display("FAIL %s byte %02h bit%0d: txd=%b in %0d cycles, required %b",
                 tag, b, k, seen, bad, exp_bits[k]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd: got %b, required 1", txd); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL reset_status: got %08h, required 00000004", d); end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h1) begin n_errors++; $display("FAIL reset_ctrl: got %08h, required 00000001", d); end
    bus_read(2'd0, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL txdata_read: got %08h, required 0", d); end
    bus_read(2'd3, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reserved_read: got %08h, required 0", d); end
    @(negedge clk);
    bus.ena = 1'b1; bus.DM_R = 1'b0; bus.DM_addr = 11'd1;
    #1;
    n_checks++;
    if (bus.DM_rdata !== 32'h0) begin n_errors++; $display("FAIL rdata_no_read: got %08h, required 0", bus.DM_rdata); end
    bus.ena = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] d;
    bus_write(2'd0, 32'hFFFF_FFA5);
    expect_frame(8'hA5, "single");
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL single_idle_status: got %08h, required 00000004", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    bus_write(2'd0, 32'h33);
    bus_read(2'd1, d);
    n_checks++;
    if (d !== status_word(0, 0, 0, 0, 3)) begin
      n_errors++; $display("FAIL b2b_count3: got %08h, required %08h", d, status_word(0, 0, 0, 0, 3));
    end
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL b2b_ctrl_off: got %08h, required 0", d); end
    bus_write(2'd2, 32'h1);
    fork
      begin
        expect_frame(8'h11, "b2b");
        expect_frame(8'h22, "b2b");
        expect_frame(8'h33, "b2b");
      end
      begin
        logic [31:0] s;
        @(posedge clk);
        bus_read(2'd1, s);
        n_checks++;
        if (s !== status_word(1, 0, 0, 0, 2)) begin
          n_errors++; $display("FAIL b2b_count2: got %08h, required %08h", s, status_word(1, 0, 0, 0, 2));
        end
      end
    join
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL b2b_final: got %08h, required 00000004", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  bytes [DEPTH+1];
    logic [7:0]  extra;
    bus_write(2'd2, 32'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      bytes[i] = 8'($urandom);
      bus_write(2'd0, {24'($urandom), bytes[i]});
    end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== status_word(0, 1, 0, 1, DEPTH)) begin
      n_errors++; $display("FAIL ovf_full: got %08h, required %08h", d, status_word(0, 1, 0, 1, DEPTH));
    end
    bus_write(2'd2, 32'h2);
    bus_read(2'd2, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL ovf_clr_ctrl: got %08h, required 0", d); end
    bus_read(2'd1, d);
    n_checks++;
    if (d !== status_word(0, 1, 0, 0, DEPTH)) begin
      n_errors++; $display("FAIL ovf_cleared: got %08h, required %08h", d, status_word(0, 1, 0, 0, DEPTH));
    end
    // Simultaneous read+write of CTRL: read shows the pre-write value
    @(negedge clk);
    bus.ena = 1'b1; bus.DM_W = 1'b1; bus.DM_R = 1'b1; bus.DM_addr = 11'd2; bus.DM_wdata = 32'h1;
    #1;
    n_checks++;
    if (bus.DM_rdata !== 32'h0) begin n_errors++; $display("FAIL rw_prewrite: got %08h, required 0", bus.DM_rdata); end
    @(posedge clk); #1;
    bus.ena = 1'b0; bus.DM_W = 1'b0; bus.DM_R = 1'b0;
    extra = 8'($urandom);
    fork
      begin
        for (int i = 0; i < DEPTH; i++) expect_frame(bytes[i], "drain");
        expect_frame(extra, "drain_extra");
      end
      begin
        logic [31:0] s;
        bus_write(2'd0, {24'h0, extra});
        bus_read(2'd1, s);
        n_checks++;
        if (s !== status_word(1, 1, 0, 0, DEPTH)) begin
          n_errors++; $display("FAIL push_pop_full: got %08h, required %08h", s, status_word(1, 1, 0, 0, DEPTH));
        end
      end
    join
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL drain_final: got %08h, required 00000004", d); end
  endtask

  task automatic test_ctrl_bits();
    logic [31:0] d;
    logic [31:0] exp;
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h5);
`ifdef DM_UART_TX_PARITY_EN
    exp = 32'h5;
`else
    exp = 32'h1;
`endif
    bus_read(2'd2, d);
    n_checks++;
    if (d !== exp) begin n_errors++; $display("FAIL ctrl_bit2: got %08h, required %08h", d, exp); end
    bus_write(2'd2, 32'h1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int         n;
      logic [7:0] q [$];
      n = $urandom_range(DEPTH, 1);
      odd_mode = 1'($urandom);
      bus_write(2'd2, {29'd0, odd_mode, 2'b01});
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      fork
        begin
          for (int i = 0; i < n; i++) bus_write(2'd0, {24'($urandom), q[i]});
        end
        begin
          @(negedge clk); @(posedge clk);
          for (int i = 0; i < n; i++) expect_frame(q[i], "random");
        end
      join
    end
    odd_mode = 1'b0;
    bus_write(2'd2, 32'h1);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int          bad;
    bus_write(2'd0, 32'hF0);
    bus_write(2'd0, 32'h5A);
    // Start bit began at the second write edge; data bit 3 begins 4 bit-times later
    repeat (4 * CLK_DIV + 1) @(posedge clk);
    #2;
    n_checks++;
    if (txd !== 1'b0) begin n_errors++; $display("FAIL pre_reset_bit3: got %b, required 0", txd); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (txd !== 1'b1) begin n_errors++; $display("FAIL async_reset_txd: got %b, required 1", txd); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    bus_read(2'd1, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL post_reset_status: got %08h, required 00000004", d); end
    bad = 0;
    for (int c = 0; c < 12 * CLK_DIV; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL post_reset_idle: txd low %0d cycles, required 0", bad); end
  endtask

`ifdef DM_UART_TX_PARITY_EN
  task automatic test_parity();
    bus_write(2'd2, 32'h1);
    odd_mode = 1'b0;
    bus_write(2'd0, 32'h07);
    expect_frame(8'h07, "parity_even");
    bus_write(2'd2, 32'h5);
    odd_mode = 1'b1;
    bus_write(2'd0, 32'h07);
    expect_frame(8'h07, "parity_odd");
    bus_write(2'd2, 32'h1);
    odd_mode = 1'b0;
  endtask
`endif

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.ena = 1'b0; bus.DM_W = 1'b0; bus.DM_R = 1'b0;
    bus.DM_addr = '0; bus.DM_wdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_ctrl_bits();
    test_random();
`ifdef DM_UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dm_uart_tx.md
# dm_uart_tx

Memory-mapped UART transmitter that responds on the CPU31 data-memory port (DM_W/DM_R/DM_addr/DM_wdata/DM_rdata), in parallel with DMEM, selected by top-level address decode. The CPU writes bytes into a TX FIFO and polls a status register. A baud-rate FSM serialises each byte as an 8N1 frame on `txd`. Reads are combinational, matching the single-cycle DMEM read contract; writes take effect on the rising clock edge.

## Interface
- CLK_DIV, 868: clock cycles per serial bit (100 MHz / 115200); legal ≥ 2.
- FIFO_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  block select from top-level decode; qualifies DM_W/DM_R.
- DM_W  in  1  write strobe.
- DM_R  in  1  read strobe.
- DM_addr  in  11  word address; only [1:0] decoded, [10:2] ignored.
- DM_wdata  in  32  write data.
- DM_rdata  out  32  read data; 0 unless ena&DM_R.
- txd  out  1  serial output, idle high.

## Operation
- Register map, by DM_addr[1:0]:
  - 0 TXDATA: write pushes DM_wdata[7:0]; reads 0.
  - 1 STATUS (RO): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[16:8] FIFO count; other bits 0.
  - 2 CTRL: bit0 tx_en (reset 1), R/W; writing bit1=1 clears overflow; bit1 reads 0.
  - 3 reserved: reads 0, writes ignored.
- Write to TXDATA while full: data dropped, overflow set.
- DM_W and DM_R both high with ena: write performed; rdata shows pre-write value.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE: txd=1. If tx_en and FIFO non-empty: pop into shift register, go START.
  - START: txd=0 for CLK_DIV cycles -> DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; 3-bit bit counter -> STOP after bit 7.
  - STOP: txd=1 for CLK_DIV cycles. Then, if tx_en and FIFO non-empty: pop, go START (no idle gap); else IDLE.
- tx_en cleared mid-frame: current frame completes; no new frame starts.
- Push and pop in the same cycle while full: write accepted, count unchanged, no overflow.
- Baud counter width: $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps on each bit boundary.

## Timing
- Reset values: txd=1, DM_rdata=0, FSM IDLE, FIFO empty, overflow=0, tx_en=1, counters 0.
- Asynchronous reset mid-frame: txd returns to 1 immediately and FIFO contents are discarded.
- Write latency: the FIFO count is visible in STATUS in the cycle after the write edge.
- Start-bit latency: with FSM idle, txd falls at the first clock edge after the TXDATA write edge. STATUS.busy=1 from that edge.
- Frame length: 10*CLK_DIV cycles (11*CLK_DIV with parity).
- DM_rdata: purely combinational from ena, DM_R, DM_addr and current register state.

## Configuration
- DM_UART_TX_PARITY_EN defined:
  - PARITY state inserted between DATA and STOP, transmitting the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - CTRL bit2 selects odd parity when 1 (reset 0).
- Not defined: 8N1 only; CTRL bit2 reads 0 and writes to it are ignored.

## Structure
- Package dm_uart_pkg: register index constants (REG_TXDATA=0, REG_STATUS=1, REG_CTRL=2), STATUS/CTRL bit positions, FSM state enum.
- Sub-module dm_uart_fifo: synchronous FIFO with push, pop, dout, full, empty and count. Pointers are $clog2(FIFO_DEPTH) wide, with count one bit wider; same clk/rst.

## Test plan
- Reset, then read STATUS -> 0x0000_0004 (empty); CTRL -> 0x1; txd=1.
- CLK_DIV=4: write 0xA5 to TXDATA -> txd low one cycle later for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high; busy clears after 40 cycles.
- Write 0x11,0x22,0x33 back-to-back -> STATUS count 3 then 2; three frames contiguous with no idle gap; final STATUS=0x4.
- Clear tx_en, then write FIFO_DEPTH+1 bytes -> full=1, overflow=1, count=FIFO_DEPTH. Write CTRL=0x2 -> overflow 0, tx_en 0. Set tx_en -> drain starts.
- Assert rst mid-DATA bit 3 -> txd=1 asynchronously, STATUS=0x4 after release, no partial frame resumes.
- With DM_UART_TX_PARITY_EN: send 0x07 -> parity bit 1 (even), frame 44 cycles at CLK_DIV=4. With CTRL bit2=1 -> parity bit 0.
